// File: rtl/regfile_writeback_queue.sv
// Merges LSU (port A) and ALU (port B) results into an in-order FIFO that drains one register-file write per cycle.
// Optional WB_PENDING_CHECK_EN adds in-flight destination lookup ports and an occupancy assertion.
module regfile_writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_DEPTH  = 32,
  parameter int Q_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [$clog2(REG_DEPTH)-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0]        a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [$clog2(REG_DEPTH)-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0]        b_data,
  output logic                         rf_we,
  output logic [$clog2(REG_DEPTH)-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
`ifdef WB_PENDING_CHECK_EN
  input  logic [$clog2(REG_DEPTH)-1:0] chk_rs1,
  input  logic [$clog2(REG_DEPTH)-1:0] chk_rs2,
  output logic                         rs1_pending,
  output logic                         rs2_pending,
`endif
  output logic [$clog2(Q_DEPTH):0]     q_count
);
  localparam int AW = $clog2(REG_DEPTH);
  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0]         rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_ent_t;

  wb_ent_t         mem [Q_DEPTH];
  logic [PW-1:0]   head, tail, tail_b;
  logic [CW-1:0]   count, free;
  logic            push_a, push_b, pop;

  // Credit only registered occupancy so ready never waits on the pop path.
  assign free    = CW'(Q_DEPTH) - count;
  assign a_ready = free >= CW'(1);
  assign b_ready = a_valid ? (free >= CW'(2)) : (free >= CW'(1));

  // x0 writes complete the handshake but are never queued.
  assign push_a  = a_valid & a_ready & (|a_rd);
  assign push_b  = b_valid & b_ready & (|b_rd);
  assign pop     = count != '0;
  assign tail_b  = tail + PW'(push_a);
  assign q_count = count;

  always_ff @(posedge clk) begin
    if (push_a) mem[tail]   <= '{rd: a_rd, data: a_data};
    if (push_b) mem[tail_b] <= '{rd: b_rd, data: b_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push_a) + PW'(push_b);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
      rf_we <= pop;
      if (pop) begin
        rf_waddr <= mem[head].rd;
        rf_wdata <= mem[head].data;
      end
    end
  end

`ifdef WB_PENDING_CHECK_EN
  logic [Q_DEPTH-1:0] hit1, hit2;

  for (genvar i = 0; i < Q_DEPTH; i++) begin : g_pend
    logic [PW-1:0] ofs;
    logic          ent_vld;
    // Entry is live when its distance from head is below occupancy.
    assign ofs     = PW'(i) - head;
    assign ent_vld = {1'b0, ofs} < count;
    assign hit1[i] = ent_vld && (mem[i].rd == chk_rs1);
    assign hit2[i] = ent_vld && (mem[i].rd == chk_rs2);
  end

  assign rs1_pending = (|chk_rs1) && ((|hit1) || (rf_we && (rf_waddr == chk_rs1)));
  assign rs2_pending = (|chk_rs2) && ((|hit2) || (rf_we && (rf_waddr == chk_rs2)));

  always_ff @(posedge clk) begin
    if (!reset) assert (count <= CW'(Q_DEPTH));
  end
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue with a scoreboard of expected register-file writes.
module tb_regfile_writeback_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd = '0, b_rd = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  q_count;
`ifdef WB_PENDING_CHECK_EN
  logic [4:0]  chk_rs1 = '0, chk_rs2 = '0;
  logic        rs1_pending, rs2_pending;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [36:0] exp_q [$];

  regfile_writeback_queue #(.DATA_WIDTH(32), .REG_DEPTH(32), .Q_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WB_PENDING_CHECK_EN
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
`endif
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write", rf_waddr, rf_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wb_order", {27'd0, rf_waddr, rf_wdata}, {27'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present both ports for one edge; readies are checked against hand values mid-cycle.
  task automatic issue(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic exp_ar, input logic exp_br);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    #3;
    chk("a_ready", a_ready, exp_ar);
    chk("b_ready", b_ready, exp_br);
    if (av && a_ready && ard != 0) exp_q.push_back({ard, ad});
    if (bv && b_ready && brd != 0) exp_q.push_back({brd, bd});
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    int cnt_tbl [6] = '{0, 2, 3, 3, 3, 3};
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_q_count", q_count, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);

    // Single write, 2-edge latency
    issue(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 1);
    chk("single_cnt", q_count, 1);
    tick();
    chk("single_we", rf_we, 1);
    chk("single_addr", rf_waddr, 5);
    chk("single_data", rf_wdata, 32'hDEADBEEF);
    chk("single_cnt0", q_count, 0);
    tick();
    chk("single_we_off", rf_we, 0);
    chk("single_hold", rf_waddr, 5);

    // Same rd from both ports: A first, B wins
    issue(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 1, 1);
    chk("dual_cnt", q_count, 2);
    tick();
    chk("dual_first", rf_wdata, 32'h11);
    tick();
    chk("dual_second", rf_wdata, 32'h22);
    chk("dual_addr", rf_waddr, 7);
    tick();
    chk("dual_idle", rf_we, 0);

    // x0 drop
    issue(0, 5'd0, 32'h0, 1, 5'd0, 32'h55, 1, 1);
    chk("x0_cnt", q_count, 0);
    tick();
    chk("x0_we", rf_we, 0);

    // Back-pressure: B held stable once refused
    for (int i = 0; i < 6; i++) begin
      chk("bp_cnt", q_count, cnt_tbl[i]);
      if (i < 2) issue(1, 5'(i + 1), 32'hA0 + i, 1, 5'(i + 17), 32'hB0 + i, 1, 1);
      else       issue(1, 5'(i + 1), 32'hA0 + i, 1, 5'd19, 32'hB2, 1, 0);
    end
    chk("bp_cnt_hi", q_count, 3);
    issue(0, 5'd0, 32'h0, 1, 5'd19, 32'hB2, 1, 1);
    repeat (6) tick();
    chk("bp_drained", q_count, 0);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Reset with stale entries
    issue(1, 5'd10, 32'h100, 1, 5'd11, 32'h101, 1, 1);
    issue(1, 5'd12, 32'h102, 0, 5'd0, 32'h0, 1, 1);
    reset = 1'b1;
    tick();
    exp_q.delete();
    reset = 1'b0;
    chk("stale_cnt", q_count, 0);
    chk("stale_we", rf_we, 0);
    repeat (6) tick();
    chk("stale_cnt_after", q_count, 0);

`ifdef WB_PENDING_CHECK_EN
    chk_rs1 = 5'd9; chk_rs2 = 5'd0;
    issue(1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 1, 1);
    chk("pend_rs1_q", rs1_pending, 1);
    chk("pend_rs2_x0", rs2_pending, 0);
    tick();
    chk("pend_rs1_out", rs1_pending, 1);
    tick();
    chk("pend_rs1_clr", rs1_pending, 0);
`endif

    repeat (3) tick();
    chk("final_sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
